zacore_fetch: RTL and testbench
===============================

Name: zacore_fetch

Overview:
Instruction fetch stage of the Zacore pipeline. It is the producer side of the fetch→decode interface. It generates sequential PCs and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel. Returned instructions are buffered and presented to decode through a registered fetch_decode_if_t output. Decode stall and execute invalidate/redirect are honoured.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset; bits [1:0] must be 0
DEPTH, 4, buffer entries; also the maximum number of requests in flight plus instructions buffered (minimum 2)

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  asynchronous, active-high reset
o_imem_req_valid  out  1  instruction memory request valid
o_imem_req_addr  out  32  word-aligned fetch address
i_imem_req_ready  in  1  memory accepts the request this cycle
i_imem_rsp_valid  in  1  response valid; one per accepted request, in order, latency ≥1 cycle
i_imem_rsp_data  in  32  instruction word
o_fetch_decode_if  out  fetch_decode_if_t  registered {valid, pc, inst} to decode
i_stall  in  1  decode stall (decode's o_stall); holds the output register
i_invalidate  in  1  flush and redirect from execute
i_redirect_pc  in  32  new PC, sampled when i_invalidate=1; bits [1:0] are forced to 0

Behaviour:
- Reset (async):
  - req_pc=RESET_PC; inflight=0; discard=0; buffer empty.
  - o_imem_req_valid=0; o_fetch_decode_if.valid=0; pc=0; inst=0.
- State:
  - req_pc (next fetch address).
  - inflight: accepted requests with no response yet, width $clog2(DEPTH+1).
  - discard: responses still to drop.
  - Buffer of DEPTH entries {pc, inst, filled} with alloc, fill and read pointers, each wrapping modulo DEPTH.
- Request issue:
  - o_imem_req_valid = !i_invalidate && (inflight + buffered_filled < DEPTH). buffered_filled counts filled entries not yet moved to the output register.
  - o_imem_req_addr = req_pc.
  - On valid&&ready: allocate an entry tagged with req_pc; req_pc += 4, wrapping at 2^32; inflight++.
  - While valid=1 and ready=0, addr is held stable. The only permitted withdrawal of valid is an i_invalidate cycle.
- Response:
  - Each i_imem_rsp_valid decrements inflight.
  - If discard>0: the response is dropped and discard decrements.
  - Otherwise: inst is written into the entry at the fill pointer, filled=1, and the fill pointer advances.
  - Accept and response in the same cycle give a net inflight change of 0.
- Output register:
  - If i_stall=0, it loads from the head entry when filled: valid=1, {pc, inst}; the head is popped.
  - Otherwise, when i_stall=0, it loads valid=0.
  - If i_stall=1, the register holds all fields unchanged.
  - There is no bypass: a response in cycle N reaches the output register at the earliest at the edge ending cycle N+1.
- Invalidate (priority over stall and all other updates):
  - Next state: the buffer is emptied, with all entries and pointers reset. o_fetch_decode_if.valid=0. req_pc = {i_redirect_pc[31:2], 2'b00}.
  - discard = inflight - (i_imem_rsp_valid ? 1 : 0). A response in the invalidate cycle is dropped.
  - inflight decrements normally. No request is accepted in that cycle.
  - Fetch from the redirect PC may issue in the next cycle.
  - Back-to-back invalidates are legal; the last redirect wins.
- Boundary conditions:
  - inflight + buffered_filled = DEPTH deasserts the request, so the buffer never overflows.
  - A response while inflight=0 is a protocol violation; it is asserted against in simulation and otherwise ignored.
  - Reset mid-operation: memory is reset on the same i_rst, so no stale responses return after reset.

Decomposition:
- Package zacore_common:
  - fetch_decode_if_t (valid, pc: w_t, inst).
  - w_t.
  - New constants: INST_BYTES=4, ZACORE_RESET_PC_DEFAULT.
- Sub-module zacore_fetch_buffer, parameterised by DEPTH:
  - alloc (pc), fill (inst), pop and flush ports.
  - Outputs: head_filled, head entry, filled count.
- zacore_fetch keeps req_pc, inflight, discard, request logic and the output register.

Test Plan:
- Reset, ready=1 always, 1-cycle latency, rsp_data=pc^32'hA5A5_0000 → output pc 0x0,0x4,0x8,… back-to-back with matching inst; first valid appears 3 cycles after reset release.
- Steady fetch, then i_stall=1 for 6 cycles → output held bit-exact. req_valid drops once inflight+buffered=4. Release gives an in-order sequence with no gaps or duplicates.
- i_imem_req_ready=0 for 3 cycles with req at 0x8 → addr stays 0x8, req_pc does not advance. After accept, the next addr is 0xC.
- 3-cycle memory latency, 2 requests in flight, i_invalidate with redirect 0x102 → both stale responses dropped. The next output is pc=0x100; the output is invalid the cycle after invalidate.
- i_invalidate, i_stall=1 and i_imem_rsp_valid=1 in the same cycle → response dropped, output valid=0 next cycle (invalidate beats stall), discard = inflight-1.
- Async i_rst pulse mid-stream (not clock-aligned) → outputs clear immediately. Fetch restarts at RESET_PC with inflight=0.

Source files
------------

// File: rtl/zacore_common_pkg.sv
// Shared Zacore types: machine word and the fetch->decode handoff record.
// No logic; constants used by fetch for PC stepping and reset vector.
// Imported by fetch and its buffer.
package zacore_common;

  typedef logic [31:0] w_t;

  typedef struct packed {
    logic valid;
    w_t   pc;
    w_t   inst;
  } fetch_decode_if_t;

  localparam int unsigned INST_BYTES              = 4;
  localparam w_t          ZACORE_RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/zacore_fetch_buffer.sv
// In-order reorder slot ring: entries are allocated with their PC at request
// accept, filled with the instruction at response, popped from the head.
// Latency: a fill is visible at the head the cycle after it is written; no bypass.
module zacore_fetch_buffer
  import zacore_common::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_alloc,
  input  w_t                         i_alloc_pc,
  input  logic                       i_fill,
  input  w_t                         i_fill_inst,
  input  logic                       i_pop,
  output logic                       o_head_filled,
  output w_t                         o_head_pc,
  output w_t                         o_head_inst,
  output logic [$clog2(DEPTH+1)-1:0] o_filled_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  w_t            pc_q     [DEPTH];
  w_t            inst_q   [DEPTH];
  logic          filled_q [DEPTH];
  logic [PW-1:0] alloc_ptr_q, fill_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ring state: flush wipes everything; otherwise alloc, fill and pop touch
  // distinct slots because fetch never lets occupancy exceed DEPTH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]     <= '0;
        inst_q[i]   <= '0;
        filled_q[i] <= 1'b0;
      end
    end else if (i_flush) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]     <= '0;
        inst_q[i]   <= '0;
        filled_q[i] <= 1'b0;
      end
    end else begin
      if (i_alloc) begin
        pc_q[alloc_ptr_q]     <= i_alloc_pc;
        filled_q[alloc_ptr_q] <= 1'b0;
        alloc_ptr_q           <= ptr_inc(alloc_ptr_q);
      end
      if (i_fill) begin
        inst_q[fill_ptr_q]   <= i_fill_inst;
        filled_q[fill_ptr_q] <= 1'b1;
        fill_ptr_q           <= ptr_inc(fill_ptr_q);
      end
      if (i_pop) begin
        filled_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_q + CW'(i_fill) - CW'(i_pop);
    end
  end

  assign o_head_filled = filled_q[rd_ptr_q];
  assign o_head_pc     = pc_q[rd_ptr_q];
  assign o_head_inst   = inst_q[rd_ptr_q];
  assign o_filled_cnt  = cnt_q;

endmodule

// File: rtl/zacore_fetch.sv
// Fetch stage: sequential PC generation, imem request/response tracking, registered decode output.
// Latency: response in cycle N reaches decode at the edge ending N+1 at the earliest.
// Backpressure: decode stall holds the output; requests stop when in-flight plus buffered reaches DEPTH.
module zacore_fetch
  import zacore_common::*;
#(
  parameter w_t          RESET_PC = ZACORE_RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_imem_req_valid,
  output w_t               o_imem_req_addr,
  input  logic             i_imem_req_ready,
  input  logic             i_imem_rsp_valid,
  input  w_t               i_imem_rsp_data,
  output fetch_decode_if_t o_fetch_decode_if,
  input  logic             i_stall,
  input  logic             i_invalidate,
  input  w_t               i_redirect_pc
);

  localparam int unsigned   IW      = $clog2(DEPTH + 1);
  localparam logic [IW:0]   DEPTH_C = (IW + 1)'(DEPTH);
  localparam w_t            ALIGN_M = ~w_t'(INST_BYTES - 1);

  w_t               req_pc_q, req_pc_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic [IW-1:0]    discard_q, discard_d;
  fetch_decode_if_t out_q, out_d;

  logic             head_filled;
  w_t               head_pc, head_inst;
  logic [IW-1:0]    filled_cnt;
  logic [IW:0]      occupancy;
  logic             accept, rsp_ok, fill, pop;

  // A response with nothing outstanding is ignored entirely.
  assign rsp_ok    = i_imem_rsp_valid && (inflight_q != '0);
  assign occupancy = {1'b0, inflight_q} + {1'b0, filled_cnt};
  assign o_imem_req_valid = !i_rst && !i_invalidate && (occupancy < DEPTH_C);
  assign o_imem_req_addr  = req_pc_q;
  assign accept = o_imem_req_valid && i_imem_req_ready;
  assign fill   = rsp_ok && !i_invalidate && (discard_q == '0);
  assign pop    = !i_invalidate && !i_stall && head_filled;

  zacore_fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_flush       (i_invalidate),
    .i_alloc       (accept),
    .i_alloc_pc    (req_pc_q),
    .i_fill        (fill),
    .i_fill_inst   (i_imem_rsp_data),
    .i_pop         (pop),
    .o_head_filled (head_filled),
    .o_head_pc     (head_pc),
    .o_head_inst   (head_inst),
    .o_filled_cnt  (filled_cnt)
  );

  // Next-state: invalidate redirects and converts all outstanding requests
  // into responses to drop; otherwise step the PC and feed the output register.
  always_comb begin
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q + IW'(accept) - IW'(rsp_ok);
    discard_d  = discard_q;
    out_d      = out_q;
    if (i_invalidate) begin
      req_pc_d    = i_redirect_pc & ALIGN_M;
      discard_d   = inflight_q - IW'(rsp_ok);
      out_d.valid = 1'b0;
    end else begin
      if (accept) begin
        req_pc_d = req_pc_q + w_t'(INST_BYTES);
      end
      if (rsp_ok && (discard_q != '0)) begin
        discard_d = discard_q - IW'(1);
      end
      if (!i_stall) begin
        if (head_filled) begin
          out_d.valid = 1'b1;
          out_d.pc    = head_pc;
          out_d.inst  = head_inst;
        end else begin
          out_d.valid = 1'b0;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      out_q      <= '0;
    end else begin
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      out_q      <= out_d;
    end
  end

  assign o_fetch_decode_if = out_q;

  // Memory must never answer a request that was not issued.
  a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_imem_rsp_valid && (inflight_q == '0)));

endmodule

// File: tb/tb_zacore_fetch.sv
module tb_zacore_fetch;
  import zacore_common::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             o_imem_req_valid;
  w_t               o_imem_req_addr;
  logic             i_imem_req_ready = 1'b1;
  logic             i_imem_rsp_valid = 1'b0;
  w_t               i_imem_rsp_data = '0;
  fetch_decode_if_t dec;
  logic             i_stall = 1'b0;
  logic             i_invalidate = 1'b0;
  w_t               i_redirect_pc = '0;

  zacore_fetch #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .o_imem_req_valid  (o_imem_req_valid),
    .o_imem_req_addr   (o_imem_req_addr),
    .i_imem_req_ready  (i_imem_req_ready),
    .i_imem_rsp_valid  (i_imem_rsp_valid),
    .i_imem_rsp_data   (i_imem_rsp_data),
    .o_fetch_decode_if (dec),
    .i_stall           (i_stall),
    .i_invalidate      (i_invalidate),
    .i_redirect_pc     (i_redirect_pc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] model_pc = 32'h0;
  logic        acc_n = 1'b0;
  logic        rsp_n = 1'b0;
  logic [31:0] addr_n = '0;

  // Reset wipes the memory model and scoreboard, as the real memory shares the reset.
  always @(posedge i_rst) begin
    pend.delete();
    exp_q.delete();
    i_imem_rsp_valid = 1'b0;
    model_pc = 32'h0;
    acc_n = 1'b0;
    rsp_n = 1'b0;
  end

  // Mid-cycle: latch handshake state and score decode output consumption.
  always @(negedge i_clk) begin
    if (i_rst) begin
      acc_n = 1'b0;
      rsp_n = 1'b0;
    end else begin
      acc_n  = o_imem_req_valid && i_imem_req_ready;
      addr_n = o_imem_req_addr;
      rsp_n  = i_imem_rsp_valid;
      if (i_invalidate) begin
        exp_q.delete();
        model_pc = i_redirect_pc & 32'hFFFF_FFFC;
      end else if (dec.valid && !i_stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_extra: got pc=%h inst=%h, required no output", dec.pc, dec.inst);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (dec.pc !== e.pc || dec.inst !== e.inst) begin
            n_bad++;
            $display("FAIL sb_order: got pc=%h inst=%h, required pc=%h inst=%h",
                     dec.pc, dec.inst, e.pc, e.inst);
          end
        end
      end
    end
  end

  // Memory: fixed-latency in-order responder; expected results pushed on accept.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      cyc++;
      if (rsp_n && pend.size() > 0) void'(pend.pop_front());
      if (acc_n) begin
        n_cmp++;
        if (addr_n !== model_pc) begin
          n_bad++;
          $display("FAIL req_addr: got %h, required %h", addr_n, model_pc);
        end
        pend.push_back('{addr_n, cyc - 1 + mem_lat});
        exp_q.push_back('{model_pc, model_pc ^ KEY});
        model_pc = model_pc + 32'd4;
      end
      #1;
      if (!i_rst && pend.size() > 0 && pend[0].due <= cyc) begin
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = pend[0].addr ^ KEY;
      end else begin
        i_imem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    step();
    #1;
    i_rst = 1'b1;
    mem_lat = lat;
    i_imem_req_ready = 1'b1;
    i_stall = 1'b0;
    i_invalidate = 1'b0;
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      step();
      if (dec.valid) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    step();
    n_cmp++;
    if (o_imem_req_valid !== 1'b0 || dec !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got req_valid=%b out=%h, required 0/0", o_imem_req_valid, dec);
    end
    do_reset(1);
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if (dec.valid !== (k == 3)) begin
        n_bad++;
        $display("FAIL first_valid_c%0d: got valid=%b, required %b", k, dec.valid, k == 3);
      end
    end
    n_cmp++;
    if (dec.pc !== 32'h0 || dec.inst !== KEY) begin
      n_bad++;
      $display("FAIL first_out: got pc=%h inst=%h, required 0/%h", dec.pc, dec.inst, KEY);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++;
      if (dec.valid !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_gap_%0d: got valid=%b, required 1", k, dec.valid);
      end
    end
  endtask

  task automatic test_stall();
    fetch_decode_if_t held;
    step();
    i_stall = 1'b1;
    held = dec;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (dec !== held) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got %h, required %h", k, dec, held);
      end
    end
    n_cmp++;
    if (o_imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_full: got req_valid=%b, required 0", o_imem_req_valid);
    end
    i_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (dec.valid !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_release_%0d: got valid=%b, required 1", k, dec.valid);
      end
    end
  endtask

  task automatic test_req_hold();
    do_reset(1);
    step();
    step();
    i_imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'h8) begin
        n_bad++;
        $display("FAIL req_hold_%0d: got valid=%b addr=%h, required 1/00000008",
                 k, o_imem_req_valid, o_imem_req_addr);
      end
      step();
    end
    i_imem_req_ready = 1'b1;
    step();
    n_cmp++;
    if (o_imem_req_addr !== 32'hC) begin
      n_bad++;
      $display("FAIL req_next: got addr=%h, required 0000000c", o_imem_req_addr);
    end
  endtask

  task automatic test_invalidate();
    bit found;
    do_reset(3);
    step();
    step();
    i_imem_req_ready = 1'b0;
    i_invalidate = 1'b1;
    i_redirect_pc = 32'h102;
    step();
    i_invalidate = 1'b0;
    i_imem_req_ready = 1'b1;
    n_cmp++;
    if (dec.valid !== 1'b0 || o_imem_req_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL inv_after: got valid=%b addr=%h, required 0/00000100", dec.valid, o_imem_req_addr);
    end
    wait_valid(20, found);
    n_cmp++;
    if (!found || dec.pc !== 32'h100 || dec.inst !== (32'h100 ^ KEY)) begin
      n_bad++;
      $display("FAIL inv_redirect: got found=%b pc=%h inst=%h, required 1/00000100/%h",
               found, dec.pc, dec.inst, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_inv_stall_rsp();
    bit found;
    do_reset(2);
    for (int k = 0; k < 8; k++) step();
    n_cmp++;
    if (dec.valid !== 1'b1) begin
      n_bad++;
      $display("FAIL isr_pre: got valid=%b, required 1", dec.valid);
    end
    i_invalidate = 1'b1;
    i_stall = 1'b1;
    i_redirect_pc = 32'h200;
    step();
    i_invalidate = 1'b0;
    i_stall = 1'b0;
    n_cmp++;
    if (dec.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL isr_inv_beats_stall: got valid=%b, required 0", dec.valid);
    end
    wait_valid(20, found);
    n_cmp++;
    if (!found || dec.pc !== 32'h200 || dec.inst !== (32'h200 ^ KEY)) begin
      n_bad++;
      $display("FAIL isr_redirect: got found=%b pc=%h inst=%h, required 1/00000200/%h",
               found, dec.pc, dec.inst, 32'h200 ^ KEY);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset(1);
    for (int k = 0; k < 6; k++) step();
    #2;
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (dec !== '0 || o_imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst: got out=%h req_valid=%b, required 0/0", dec, o_imem_req_valid);
    end
    step();
    #2;
    i_rst = 1'b0;
    n_cmp++;
    if (o_imem_req_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_pc: got addr=%h, required 00000000", o_imem_req_addr);
    end
    wait_valid(10, found);
    n_cmp++;
    if (!found || dec.pc !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_restart: got found=%b pc=%h, required 1/00000000", found, dec.pc);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_req_hold();
    test_invalidate();
    test_inv_stall_rsp();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
